// File: rtl/cpu_pkg.sv
// Shared definitions for the sMIPS pipeline: default geometry, PC reset value
// and stage indices.
package cpu_pkg;

  localparam int          NUM_STAGES_DEF = 5;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } stage_e;

  // Width needed to hold a stage index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int STAGE_IDX_W = idx_w(NUM_STAGES_DEF);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for pipeline performance statistics; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stage valid tracking, stall/flush resolution into
// per-stage load enables and kills, registered fetch redirect, perf counters.
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int              N_STAGES = NUM_STAGES_DEF,
  parameter int              PC_W     = 32,
  parameter int              CNT_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
  localparam int             IDX_W    = idx_w(N_STAGES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_valid_i,
  input  logic [N_STAGES-1:0] stall_req_i,
  input  logic                flush_req_i,
  input  logic [IDX_W-1:0]    flush_upto_i,
  input  logic [PC_W-1:0]     redirect_pc_i,
  output logic [N_STAGES-1:0] stage_en_o,
  output logic [N_STAGES-1:0] stage_valid_o,
  output logic [N_STAGES-1:0] stage_kill_o,
  output logic                redirect_vld_o,
  output logic [PC_W-1:0]     redirect_pc_o,
  output logic                retire_o,
  output logic [CNT_W-1:0]    stall_cnt_o,
  output logic [CNT_W-1:0]    retire_cnt_o
);

  logic [N_STAGES-1:0] valid_q, valid_d;
  logic [N_STAGES-1:0] stall_act, kill, en, live, shift_in;
  logic [IDX_W-1:0]    stall_src, upto;
  logic                any_stall, stall_eff;

  assign stall_act = rst ? '0 : stall_req_i;

  // Oldest (highest-index) stalling stage wins.
  always_comb begin
    stall_src = '0;
    any_stall = 1'b0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (stall_act[i]) begin
        stall_src = IDX_W'(i);
        any_stall = 1'b1;
      end
    end
  end

  assign upto = (flush_upto_i > IDX_W'(N_STAGES - 1)) ? IDX_W'(N_STAGES - 1) : flush_upto_i;

  // A stall whose source is itself being flushed no longer holds anything.
  assign stall_eff = any_stall && !(flush_req_i && (stall_src <= upto));

  assign live     = valid_q & ~kill;
  assign shift_in = {live[N_STAGES-2:0], fetch_valid_i};

  always_comb begin
    kill    = '0;
    en      = '1;
    valid_d = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      kill[i] = flush_req_i && (IDX_W'(i) <= upto);
    end
    for (int i = 0; i < N_STAGES; i++) begin
      if (stall_eff && (IDX_W'(i) <= stall_src)) begin
        en[i]      = 1'b0;
        valid_d[i] = valid_q[i];
      end else if (stall_eff && (i > 0) && (IDX_W'(i - 1) == stall_src)) begin
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i] = shift_in[i];
      end
      valid_d[i] = valid_d[i] & ~kill[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= '0;
      redirect_vld_o <= 1'b0;
      redirect_pc_o  <= RESET_PC;
    end else begin
      valid_q        <= valid_d;
      redirect_vld_o <= flush_req_i;
      if (flush_req_i) begin
        redirect_pc_o <= redirect_pc_i;
      end
    end
  end

  assign stage_en_o    = en;
  assign stage_valid_o = valid_q;
  assign stage_kill_o  = kill;
  assign retire_o      = valid_q[N_STAGES-1] & ~stall_act[N_STAGES-1] & ~kill[N_STAGES-1];

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (any_stall),
    .count (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire_o),
    .count (retire_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl (N=5, 4-bit counters): each driven cycle queues
// its hand-computed expected outputs, a negedge monitor pops and compares them.
module tb_pipe_ctrl;

  localparam logic [7:0] ALL  = 8'hFF;
  localparam logic [7:0] REGS = 8'b1101_1010;

  typedef struct {
    string       name;
    logic [7:0]  chk;
    logic [4:0]  en;
    logic [4:0]  valid;
    logic [4:0]  kill;
    logic        rvld;
    logic [31:0] rpc;
    logic        retire;
    logic [3:0]  sc;
    logic [3:0]  rc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [4:0]  stall_req;
  logic        flush_req;
  logic [2:0]  flush_upto;
  logic [31:0] redirect_pc_in;
  logic [4:0]  stage_en, stage_valid, stage_kill;
  logic        redirect_vld, retire;
  logic [31:0] redirect_pc_out;
  logic [3:0]  stall_cnt, retire_cnt;

  exp_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.N_STAGES(5), .PC_W(32), .CNT_W(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_valid_i  (fetch_valid),
    .stall_req_i    (stall_req),
    .flush_req_i    (flush_req),
    .flush_upto_i   (flush_upto),
    .redirect_pc_i  (redirect_pc_in),
    .stage_en_o     (stage_en),
    .stage_valid_o  (stage_valid),
    .stage_kill_o   (stage_kill),
    .redirect_vld_o (redirect_vld),
    .redirect_pc_o  (redirect_pc_out),
    .retire_o       (retire),
    .stall_cnt_o    (stall_cnt),
    .retire_cnt_o   (retire_cnt)
  );

  task automatic apply_stimulus(
    input string name, input logic r, input logic fv, input logic [4:0] stall,
    input logic fl, input logic [2:0] upto, input logic [31:0] pc, input logic [7:0] chk,
    input logic [4:0] en, input logic [4:0] valid, input logic [4:0] kill, input logic rvld,
    input logic [31:0] rpc, input logic ret, input logic [3:0] sc, input logic [3:0] rc);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = r;
    fetch_valid    = fv;
    stall_req      = stall;
    flush_req      = fl;
    flush_upto     = upto;
    redirect_pc_in = pc;
    e.name = name; e.chk = chk; e.en = en; e.valid = valid; e.kill = kill;
    e.rvld = rvld; e.rpc = rpc; e.retire = ret; e.sc = sc; e.rc = rc;
    exp_q.push_back(e);
  endtask

  task automatic check_field(input string name, input string field,
                             input logic [31:0] act, input logic [31:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, req);
    end
  endtask

  task automatic check_output(input exp_t e);
    if (e.chk[0]) check_field(e.name, "stage_en",     32'(stage_en),        32'(e.en));
    if (e.chk[1]) check_field(e.name, "stage_valid",  32'(stage_valid),     32'(e.valid));
    if (e.chk[2]) check_field(e.name, "stage_kill",   32'(stage_kill),      32'(e.kill));
    if (e.chk[3]) check_field(e.name, "redirect_vld", 32'(redirect_vld),    32'(e.rvld));
    if (e.chk[4]) check_field(e.name, "redirect_pc",  redirect_pc_out,      e.rpc);
    if (e.chk[5]) check_field(e.name, "retire",       32'(retire),          32'(e.retire));
    if (e.chk[6]) check_field(e.name, "stall_cnt",    32'(stall_cnt),       32'(e.sc));
    if (e.chk[7]) check_field(e.name, "retire_cnt",   32'(retire_cnt),      32'(e.rc));
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; stall_req = '0; flush_req = 1'b0;
    flush_upto = '0; redirect_pc_in = '0;

    //              name         r  fv stall     fl upto  pc            chk   en        valid     kill      rv rpc           rt sc     rc
    apply_stimulus("rst0",       1, 0, 5'b00000, 0, 3'd0, 32'h0,        8'h0, 5'b11111, 5'b00000, 5'b00000, 0, 32'h0,        0, 4'd0,  4'd0);
    apply_stimulus("rst1",       1, 0, 5'b00000, 0, 3'd0, 32'h0,        ALL,  5'b11111, 5'b00000, 5'b00000, 0, 32'h0,        0, 4'd0,  4'd0);

    for (int k = 0; k < 5; k++)
      apply_stimulus("fill",     0, 1, 5'b00000, 0, 3'd0, 32'h0,        ALL,  5'b11111, 5'((1 << k) - 1), 5'b00000, 0, 32'h0, 0, 4'd0, 4'd0);
    apply_stimulus("full6",      0, 1, 5'b00000, 0, 3'd0, 32'h0,        ALL,  5'b11111, 5'b11111, 5'b00000, 0, 32'h0,        1, 4'd0,  4'd0);
    apply_stimulus("full7",      0, 1, 5'b00000, 0, 3'd0, 32'h0,        ALL,  5'b11111, 5'b11111, 5'b00000, 0, 32'h0,        1, 4'd0,  4'd1);

    apply_stimulus("stall1",     0, 1, 5'b00100, 0, 3'd0, 32'h0,        ALL,  5'b11000, 5'b11111, 5'b00000, 0, 32'h0,        1, 4'd0,  4'd2);
    apply_stimulus("stall2",     0, 1, 5'b00100, 0, 3'd0, 32'h0,        ALL,  5'b11000, 5'b10111, 5'b00000, 0, 32'h0,        1, 4'd1,  4'd3);
    apply_stimulus("stall3",     0, 1, 5'b00100, 0, 3'd0, 32'h0,        ALL,  5'b11000, 5'b00111, 5'b00000, 0, 32'h0,        0, 4'd2,  4'd4);
    apply_stimulus("release1",   0, 1, 5'b00000, 0, 3'd0, 32'h0,        ALL,  5'b11111, 5'b00111, 5'b00000, 0, 32'h0,        0, 4'd3,  4'd4);
    apply_stimulus("release2",   0, 1, 5'b00000, 0, 3'd0, 32'h0,        ALL,  5'b11111, 5'b01111, 5'b00000, 0, 32'h0,        0, 4'd3,  4'd4);
    apply_stimulus("release3",   0, 1, 5'b00000, 0, 3'd0, 32'h0,        ALL,  5'b11111, 5'b11111, 5'b00000, 0, 32'h0,        1, 4'd3,  4'd4);

    apply_stimulus("flush",      0, 1, 5'b00000, 1, 3'd1, 32'h40,       ALL,  5'b11111, 5'b11111, 5'b00011, 0, 32'h0,        1, 4'd3,  4'd5);
    apply_stimulus("flush_p1",   0, 1, 5'b00000, 0, 3'd0, 32'h0,        ALL,  5'b11111, 5'b11000, 5'b00000, 1, 32'h40,       1, 4'd3,  4'd6);
    apply_stimulus("flush_p2",   0, 1, 5'b00000, 0, 3'd0, 32'h0,        ALL,  5'b11111, 5'b10001, 5'b00000, 0, 32'h40,       1, 4'd3,  4'd7);

    apply_stimulus("stflush",    0, 1, 5'b00010, 1, 3'd2, 32'h80,       ALL,  5'b11111, 5'b00011, 5'b00111, 0, 32'h40,       0, 4'd3,  4'd8);
    apply_stimulus("stflush_p1", 0, 1, 5'b00000, 0, 3'd0, 32'h0,        ALL,  5'b11111, 5'b00000, 5'b00000, 1, 32'h80,       0, 4'd4,  4'd8);
    apply_stimulus("refill1",    0, 1, 5'b00000, 0, 3'd0, 32'h0,        ALL,  5'b11111, 5'b00001, 5'b00000, 0, 32'h80,       0, 4'd4,  4'd8);
    apply_stimulus("refill2",    0, 1, 5'b00000, 0, 3'd0, 32'h0,        ALL,  5'b11111, 5'b00011, 5'b00000, 0, 32'h80,       0, 4'd4,  4'd8);
    apply_stimulus("refill3",    0, 1, 5'b00000, 0, 3'd0, 32'h0,        ALL,  5'b11111, 5'b00111, 5'b00000, 0, 32'h80,       0, 4'd4,  4'd8);
    apply_stimulus("refill4",    0, 1, 5'b00000, 0, 3'd0, 32'h0,        ALL,  5'b11111, 5'b01111, 5'b00000, 0, 32'h80,       0, 4'd4,  4'd8);

    apply_stimulus("oldstall",   0, 1, 5'b01000, 1, 3'd1, 32'h100,      ALL,  5'b10000, 5'b11111, 5'b00011, 0, 32'h80,       1, 4'd4,  4'd8);
    apply_stimulus("oldstall_p1",0, 0, 5'b00000, 0, 3'd0, 32'h0,        ALL,  5'b11111, 5'b01100, 5'b00000, 1, 32'h100,      0, 4'd5,  4'd9);
    apply_stimulus("oldstall_p2",0, 0, 5'b00000, 0, 3'd0, 32'h0,        ALL,  5'b11111, 5'b11000, 5'b00000, 0, 32'h100,      1, 4'd5,  4'd9);

    apply_stimulus("clampflush", 0, 1, 5'b00000, 1, 3'd7, 32'h200,      ALL,  5'b11111, 5'b10000, 5'b11111, 0, 32'h100,      0, 4'd5,  4'd10);
    apply_stimulus("b2bflush",   0, 1, 5'b00000, 1, 3'd0, 32'h300,      ALL,  5'b11111, 5'b00000, 5'b00001, 1, 32'h200,      0, 4'd5,  4'd10);
    apply_stimulus("b2b_p1",     0, 0, 5'b00000, 0, 3'd0, 32'h0,        ALL,  5'b11111, 5'b00000, 5'b00000, 1, 32'h300,      0, 4'd5,  4'd10);
    apply_stimulus("b2b_p2",     0, 0, 5'b00000, 0, 3'd0, 32'h0,        ALL,  5'b11111, 5'b00000, 5'b00000, 0, 32'h300,      0, 4'd5,  4'd10);

    for (int k = 0; k < 20; k++)
      apply_stimulus("satstall", 0, 0, 5'b00001, 0, 3'd0, 32'h0,        ALL,  5'b11110, 5'b00000, 5'b00000, 0, 32'h300,      0,
                     4'((5 + k > 15) ? 15 : 5 + k), 4'd10);

    apply_stimulus("rstmid",     1, 1, 5'b00001, 1, 3'd1, 32'h400,      REGS, 5'b11111, 5'b00000, 5'b00000, 0, 32'h300,      0, 4'd15, 4'd10);
    apply_stimulus("postrst",    0, 0, 5'b00000, 0, 3'd0, 32'h0,        ALL,  5'b11111, 5'b00000, 5'b00000, 0, 32'h0,        0, 4'd0,  4'd0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_mismatched++;
      $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
